// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : Oversampling 8N1 UART receiver. Deserialises the asynchronous
//               rx_data_i line (8 ticks per bit, Prescale clocks per tick) and
//               presents each byte on a ready/valid output, with one-cycle
//               frame-error and overrun pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int          DataWidth = 8,
  parameter logic [15:0] Prescale  = 16'd27
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 rx_data_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o
);

  // bit_cnt must be able to hold DataWidth-1 even when DataWidth is 1
  localparam int              BW       = $clog2(DataWidth + 1);
  localparam logic [BW-1:0]   LAST_BIT = BW'(DataWidth - 1);
  localparam logic [15:0]     TICK_TOP = Prescale - 16'd1;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;

  logic                 sync1;
  logic                 rx_s;
  logic [15:0]          cnt;
  logic                 tick;
  logic [2:0]           tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [2:0]           state;
  logic [DataWidth-1:0] shreg;
  logic                 stop_sample;
  logic                 deliver;

  assign tick        = (cnt == TICK_TOP);
  // the stop bit is sampled on the 8th tick of the stop-bit period
  assign stop_sample = (state == STOP) && tick && (tick_cnt == 3'd7);
  assign deliver     = stop_sample && rx_s;

  // Two-flop synchroniser; idles high so reset does not look like a start bit
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx_data_i;
      rx_s  <= sync1;
    end
  end

  // Oversample tick counter, held at zero in IDLE so ticks align to the start edge
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt <= 16'd0;
    end else if (state == IDLE || tick) begin
      cnt <= 16'd0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  // Frame state machine: start qualification, data shifting, stop check
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= IDLE;
      tick_cnt <= 3'd0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      case (state)
        IDLE: begin
          tick_cnt <= 3'd0;
          if (!rx_s) begin
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            if (tick_cnt == 3'd3) begin
              tick_cnt <= 3'd0;
              bit_cnt  <= '0;
              // a line that is high again at mid start bit was only a glitch
              state    <= rx_s ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + 3'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            tick_cnt <= tick_cnt + 3'd1;
            if (tick_cnt == 3'd7) begin
              shreg   <= {rx_s, shreg[DataWidth-1:1]};
              bit_cnt <= bit_cnt + BW'(1);
              if (bit_cnt == LAST_BIT) begin
                state <= STOP;
              end
            end
          end
        end
        STOP: begin
          if (tick) begin
            tick_cnt <= tick_cnt + 3'd1;
            if (tick_cnt == 3'd7) begin
              // low stop bit: wait out the break so it reports only once
              state <= rx_s ? IDLE : WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output buffer with ready/valid handshake, overrun and frame-error pulses
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= stop_sample && !rx_s;
      overrun_o   <= 1'b0;
      if (deliver) begin
        if (!valid_o || ready_i) begin
          data_o  <= shreg;
          valid_o <= 1'b1;
        end else begin
          // buffer still owned by the consumer: keep the old byte
          overrun_o <= 1'b1;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx (Prescale=4, 32 clocks/bit).
//               Expected bytes are queued when a good frame is driven and
//               popped when the DUT hands a byte over.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int BIT_CLKS = 32;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       rx_data_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       frame_err_o;
  logic       overrun_o;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  int vcyc = 0;
  int fcnt = 0;
  int ocnt = 0;
  int v0, f0, o0;

  uart_rx #(.DataWidth(8), .Prescale(16'd4)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .rx_data_i   (rx_data_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: counts pulses and checks every handshaken byte
  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (valid_o) vcyc++;
      if (frame_err_o) fcnt++;
      if (overrun_o) ocnt++;
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_byte", {24'd0, data_o}, 32'hFFFF_FFFF);
        end else begin
          check_eq("rx_data", {24'd0, data_o}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic snap();
    v0 = vcyc; f0 = fcnt; o0 = ocnt;
  endtask

  task automatic drive_bit(input logic b);
    rx_data_i = b;
    repeat (BIT_CLKS) @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    rx_data_i = 1'b1;
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic stop_bit, input logic expect_out);
    if (expect_out) exp_q.push_back(d);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_bit);
  endtask

  initial begin
    reset_i   = 1'b1;
    rx_data_i = 1'b1;
    ready_i   = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("rst_data",  {24'd0, data_o}, 32'd0);
    check_eq("rst_valid", {31'd0, valid_o}, 32'd0);
    check_eq("rst_ferr",  {31'd0, frame_err_o}, 32'd0);
    check_eq("rst_ovr",   {31'd0, overrun_o}, 32'd0);
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    idle(10);

    // single byte, consumer always ready
    snap();
    send(8'hA5, 1'b1, 1'b1);
    idle(40);
    check_eq("a5_drained", exp_q.size(), 0);
    check_eq("a5_vcycles", vcyc - v0, 1);
    check_eq("a5_ferr",    fcnt - f0, 0);
    check_eq("a5_ovr",     ocnt - o0, 0);

    // back-to-back frames, no idle gap
    snap();
    send(8'h00, 1'b1, 1'b1);
    send(8'hFF, 1'b1, 1'b1);
    send(8'h55, 1'b1, 1'b1);
    idle(40);
    check_eq("b2b_drained", exp_q.size(), 0);
    check_eq("b2b_vcycles", vcyc - v0, 3);

    // short low glitch on an idle line is rejected
    snap();
    rx_data_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1;
    idle(40);
    check_eq("glitch_vcycles", vcyc - v0, 0);
    check_eq("glitch_ferr",    fcnt - f0, 0);
    send(8'h3C, 1'b1, 1'b1);
    idle(40);
    check_eq("3c_drained", exp_q.size(), 0);
    check_eq("3c_vcycles", vcyc - v0, 1);

    // bad stop bit followed by a break: one frame error, no byte
    snap();
    send(8'h81, 1'b0, 1'b0);
    rx_data_i = 1'b0;
    repeat (3 * BIT_CLKS) @(posedge clk_i);
    #1;
    idle(40);
    check_eq("brk_ferr",    fcnt - f0, 1);
    check_eq("brk_vcycles", vcyc - v0, 0);
    snap();
    send(8'h42, 1'b1, 1'b1);
    idle(40);
    check_eq("42_drained", exp_q.size(), 0);
    check_eq("42_vcycles", vcyc - v0, 1);
    check_eq("42_ferr",    fcnt - f0, 0);

    // consumer stalled: second byte overruns, first byte is held
    snap();
    ready_i = 1'b0;
    send(8'h11, 1'b1, 1'b1);
    send(8'h22, 1'b1, 1'b0);
    idle(40);
    check_eq("ovr_pulses",  ocnt - o0, 1);
    check_eq("ovr_valid",   {31'd0, valid_o}, 32'd1);
    check_eq("ovr_data",    {24'd0, data_o}, 32'h11);
    check_eq("ovr_pending", exp_q.size(), 1);
    ready_i = 1'b1;
    idle(5);
    check_eq("ovr_drained", exp_q.size(), 0);
    check_eq("ovr_valid_lo", {31'd0, valid_o}, 32'd0);

    // reset in the middle of data bit 4 of 0x99 discards the frame
    snap();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(((8'h99 >> i) & 8'h01) != 8'h00);
    rx_data_i = 1'b1;
    repeat (BIT_CLKS / 2) @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    @(negedge clk_i);
    check_eq("mrst_valid", {31'd0, valid_o}, 32'd0);
    check_eq("mrst_data",  {24'd0, data_o}, 32'd0);
    idle(4 * BIT_CLKS);
    check_eq("mrst_vcycles", vcyc - v0, 0);
    snap();
    send(8'h66, 1'b1, 1'b1);
    idle(40);
    check_eq("66_drained", exp_q.size(), 0);
    check_eq("66_vcycles", vcyc - v0, 1);
    check_eq("66_ferr",    fcnt - f0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Oversampling UART receiver (8N1): deserialises the asynchronous rx_data_i line into bytes.
- Presents each byte on a ready/valid output to the downstream consumer (echo/ALU command path).
- Runs on the 25.125 MHz PLL clock.
- Prescale is the number of clocks per oversample tick; 8 ticks per bit. The top level passes clk/(baud*8).

Parameters:
- DataWidth, 8: data bits per frame, LSB first.
- Prescale, 16'd27: clocks per oversample tick. Must be ≥ 2.

Ports:
- clk_i  input  1  system clock
- reset_i  input  1  synchronous, active-high reset
- rx_data_i  input  1  asynchronous serial line, idle high
- data_o  output  DataWidth  received byte
- valid_o  output  1  data_o holds an unconsumed byte
- ready_i  input  1  consumer accepts data_o when valid_o && ready_i
- frame_err_o  output  1  one-cycle pulse: stop bit sampled low
- overrun_o  output  1  one-cycle pulse: byte completed while the output buffer was full

Behaviour:
- Synchroniser
  - rx_data_i passes through 2 flops, both reset to 1.
  - rx_s is the second flop output. All logic uses rx_s only.
- Tick generator
  - 16-bit counter runs 0..Prescale-1. tick = (cnt == Prescale-1).
  - Counter is forced to 0 on start detection and in IDLE, so ticks are phase-aligned to the start edge.
- Bit counters
  - tick_cnt (3 bits) counts oversample ticks within a bit.
  - bit_cnt counts data bits.
- States
  - IDLE: rx_s == 0 → START; clear cnt and tick_cnt.
  - START: on the 4th tick (mid start bit), sample rx_s.
    - rx_s == 1 → IDLE (glitch rejected, no outputs).
    - rx_s == 0 → DATA; tick_cnt = 0; bit_cnt = 0.
  - DATA: every 8th tick, shift rx_s into shreg MSB-side (LSB-first reception); bit_cnt++.
    - After DataWidth bits → STOP.
  - STOP: on the 8th tick, sample rx_s.
    - rx_s == 1 → deliver shreg, then IDLE.
    - rx_s == 0 → frame_err_o = 1 for one cycle, shreg discarded, → WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s == 1, then → IDLE. A break condition therefore produces exactly one frame_err pulse.
- Deliver: registered, visible the cycle after the stop sample.
  - If !valid_o, or valid_o && ready_i in that same cycle: data_o ← shreg, valid_o = 1, no overrun.
  - Else (valid_o && !ready_i): data_o unchanged (old byte kept), new byte dropped, overrun_o = 1 for one cycle.
- Handshake
  - valid_o, once high, stays high with data_o stable until ready_i is sampled high.
  - valid_o && ready_i with no simultaneous delivery → valid_o = 0 next cycle.
  - ready_i is ignored while valid_o == 0.
- Latency: rx_data_i falling edge → valid_o rising ≈ 2 (sync) + (4 + 8·DataWidth + 8)·Prescale + 1 clocks.
- Reset, any state, mid-frame included:
  - State = IDLE; all counters = 0; shreg = 0; data_o = 0.
  - valid_o = 0, frame_err_o = 0, overrun_o = 0; synchroniser flops = 1.
  - A partially received frame is discarded. A line held low across reset release is treated as a new start bit.
- Width rules: counters sized from parameters ($clog2). No truncation warnings allowed.

Test Plan (Prescale=4 → 32 clocks/bit; bench drives ideal-timed frames):
- Send 0xA5 with ready_i = 1 → one valid_o cycle with data_o = 0xA5; frame_err_o = 0, overrun_o = 0.
- Send back-to-back 0x00, 0xFF, 0x55 with no idle gap, ready_i = 1 → valid_o delivers exactly 0x00, 0xFF, 0x55 in order.
- Drive a 10-clock low glitch on an idle line → no valid_o and no frame_err_o; state returns to IDLE; a following 0x3C frame is received correctly.
- Send 0x81 with the stop bit low, then hold the line low for 3 bit times, then high → single frame_err_o pulse, no valid_o; a subsequent 0x42 frame is received correctly.
- Hold ready_i = 0 and send 0x11 then 0x22 → valid_o high with data_o = 0x11 held, plus one overrun_o pulse. Then raise ready_i → 0x11 consumed, valid_o = 0.
- Assert reset_i for 1 cycle during bit 4 of 0x99, then send 0x66 → no output for the 0x99 frame; data_o = 0x66 with one valid.
